// File: rtl/al422b_frame_writer.sv
// AL422B write-side controller: crops one armed MT9V034 frame into the FIFO write port.
// Optional build macro AL422B_TEST_PATTERN_EN replaces pixel data with a {row,col} pattern.
module al422b_frame_writer #(
    parameter int IMG_W       = 384,
    parameter int IMG_H       = 288,
    parameter int H_START     = 184,
    parameter int V_START     = 96,
    parameter int WRST_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        arm,
    input  logic        frame_valid,
    input  logic        line_valid,
    input  logic [7:0]  pix_data,
    output logic        fifo_wrst_n,
    output logic        fifo_we_n,
    output logic [7:0]  fifo_di,
    output logic        busy,
    output logic        frame_done,
    output logic        short_frame,
    output logic [16:0] pix_count
);

    localparam logic [17:0] TOTAL     = 18'(IMG_W * IMG_H);
    localparam logic [10:0] H_LO      = 11'(H_START);
    localparam logic [10:0] H_HI      = 11'(H_START + IMG_W);
    localparam logic [9:0]  V_LO      = 10'(V_START);
    localparam logic [9:0]  V_HI      = 10'(V_START + IMG_H);
    localparam logic [7:0]  WRST_LAST = 8'(WRST_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_WRST, S_WAIT_FV, S_CAPTURE, S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic        fv_q, lv_q;
    logic [9:0]  col;
    logic [8:0]  row;
    logic [7:0]  wrst_cnt;
    logic        vld_p0;
    logic [7:0]  pix_p0;
    logic        fv_rise, fv_fall, in_win, wr_ok;
    logic [17:0] cnt_ahead;

    assign fv_rise   = frame_valid && !fv_q;
    assign fv_fall   = !frame_valid && fv_q;
    // Count the write already in flight so the saturation limit is exact.
    assign cnt_ahead = {1'b0, pix_count} + {17'b0, vld_p0};
    assign in_win    = ({1'b0, col} >= H_LO) && ({1'b0, col} < H_HI) &&
                       ({1'b0, row} >= V_LO) && ({1'b0, row} < V_HI);
    assign wr_ok     = (state == S_CAPTURE) && frame_valid && line_valid &&
                       in_win && (cnt_ahead < TOTAL);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (arm)                     state_nxt = S_SYNC;
            S_SYNC:    if (!frame_valid)            state_nxt = S_WRST;
            S_WRST:    if (wrst_cnt == WRST_LAST)   state_nxt = S_WAIT_FV;
            S_WAIT_FV: if (fv_rise)                 state_nxt = S_CAPTURE;
            S_CAPTURE: if (fv_fall)                 state_nxt = S_DONE;
            S_DONE:                                 state_nxt = S_IDLE;
            default:                                state_nxt = S_IDLE;
        endcase
    end

    // Stage p0: qualify the sampled pixel and capture its data.
`ifdef AL422B_TEST_PATTERN_EN
    logic [9:0] col_rel;
    logic [8:0] row_rel;
    assign col_rel = col - H_LO[9:0];
    assign row_rel = row - V_LO[8:0];
    always_ff @(posedge clk) begin
        pix_p0 <= {row_rel[3:0], col_rel[3:0]};
    end
`else
    always_ff @(posedge clk) begin
        pix_p0 <= pix_data;
    end
`endif

    // Stage p1: FSM, counters and registered FIFO port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            fv_q        <= 1'b0;
            lv_q        <= 1'b0;
            col         <= '0;
            row         <= '0;
            wrst_cnt    <= '0;
            vld_p0      <= 1'b0;
            fifo_wrst_n <= 1'b1;
            fifo_we_n   <= 1'b1;
            fifo_di     <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            short_frame <= 1'b0;
            pix_count   <= '0;
        end else begin
            state       <= state_nxt;
            fv_q        <= frame_valid;
            lv_q        <= line_valid;
            vld_p0      <= wr_ok;
            fifo_we_n   <= !vld_p0;
            fifo_wrst_n <= (state_nxt != S_WRST);
            busy        <= (state_nxt != S_IDLE);
            frame_done  <= (state == S_DONE);
            wrst_cnt    <= (state == S_WRST) ? wrst_cnt + 8'd1 : 8'd0;

            if (state == S_CAPTURE) begin
                col <= line_valid ? col + 10'd1 : 10'd0;
                if (lv_q && !line_valid)
                    row <= row + 9'd1;
            end else begin
                col <= '0;
                row <= '0;
            end

            if (vld_p0) begin
                fifo_di   <= pix_p0;
                pix_count <= pix_count + 17'd1;
            end

            if (state == S_DONE && {1'b0, pix_count} < TOTAL)
                short_frame <= 1'b1;

            if (state == S_IDLE && arm) begin
                pix_count   <= '0;
                short_frame <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_al422b_frame_writer.sv
// Directed bench for al422b_frame_writer with a small-geometry frame model and write scoreboard.
module tb_al422b_frame_writer;

    localparam int P_W  = 4;
    localparam int P_H  = 2;
    localparam int P_HS = 2;
    localparam int P_VS = 1;
    localparam int P_WR = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        arm;
    logic        frame_valid;
    logic        line_valid;
    logic [7:0]  pix_data;
    logic        fifo_wrst_n;
    logic        fifo_we_n;
    logic [7:0]  fifo_di;
    logic        busy;
    logic        frame_done;
    logic        short_frame;
    logic [16:0] pix_count;

    int total = 0;
    int bad = 0;
    int wr_seen = 0;
    int frame_wr = 0;
    int first_wr = -1;
    int last_wr = -1;
    int done_cnt = 0;
    int wrst_pulses = 0;
    int wrst_run = 0;
    int exp_q[$];

    al422b_frame_writer #(
        .IMG_W(P_W), .IMG_H(P_H), .H_START(P_HS), .V_START(P_VS), .WRST_CYCLES(P_WR)
    ) dut (
        .clk(clk), .reset(reset), .arm(arm),
        .frame_valid(frame_valid), .line_valid(line_valid), .pix_data(pix_data),
        .fifo_wrst_n(fifo_wrst_n), .fifo_we_n(fifo_we_n), .fifo_di(fifo_di),
        .busy(busy), .frame_done(frame_done), .short_frame(short_frame),
        .pix_count(pix_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Expected FIFO contents for a sensor frame of nlines x linelen, pixel value = r*linelen+c.
    task automatic expect_frame(input int nlines, input int linelen);
        int n = 0;
        for (int r = 0; r < nlines; r++)
            for (int c = 0; c < linelen; c++)
                if (r >= P_VS && r < P_VS + P_H && c >= P_HS && c < P_HS + P_W && n < P_W * P_H) begin
`ifdef AL422B_TEST_PATTERN_EN
                    exp_q.push_back(((r - P_VS) % 16) * 16 + ((c - P_HS) % 16));
`else
                    exp_q.push_back((r * linelen + c) % 256);
`endif
                    n++;
                end
    endtask

    task automatic send_frame(input int nlines, input int linelen);
        @(negedge clk);
        frame_valid = 1'b1;
        repeat (2) @(negedge clk);
        for (int r = 0; r < nlines; r++) begin
            for (int c = 0; c < linelen; c++) begin
                line_valid = 1'b1;
                pix_data   = 8'((r * linelen + c) % 256);
                @(negedge clk);
            end
            line_valid = 1'b0;
            pix_data   = 8'd0;
            repeat (2) @(negedge clk);
        end
        frame_valid = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic arm_pulse();
        @(negedge clk);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic capture(input int nlines, input int exp_cnt, input int exp_short);
        int prev_done = done_cnt;
        int prev_wrst = wrst_pulses;
        frame_wr = 0;
        expect_frame(nlines, 8);
        arm_pulse();
        repeat (8) @(negedge clk);
        send_frame(nlines, 8);
        repeat (4) @(negedge clk);
        check("done_count", done_cnt, prev_done + 1);
        check("wrst_pulses", wrst_pulses, prev_wrst + 1);
        check("writes", frame_wr, exp_cnt);
        check("pix_count", int'(pix_count), exp_cnt);
        check("short_frame", int'(short_frame), exp_short);
        check("leftover_expected", exp_q.size(), 0);
        check("busy_after", int'(busy), 0);
    endtask

    // Output monitor: scoreboard every write, track WRST pulses and frame_done.
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            if (!fifo_we_n) begin
                wr_seen++;
                if (frame_wr == 0) first_wr = int'(fifo_di);
                last_wr = int'(fifo_di);
                frame_wr++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write actual=%0d required=none", fifo_di);
                end else begin
                    check("write_data", int'(fifo_di), exp_q.pop_front());
                end
            end
            if (!fifo_wrst_n) begin
                wrst_run++;
                check("fv_low_in_wrst", int'(frame_valid), 0);
            end else if (wrst_run > 0) begin
                check("wrst_len", wrst_run, P_WR);
                wrst_pulses++;
                wrst_run = 0;
            end
            if (frame_done) begin
                done_cnt++;
                check("busy_at_done", int'(busy), 0);
            end
        end
    end

    initial begin
        int prev_done;
        int prev_wr;
        int lit_first;
        int lit_last;
        int reached;
`ifdef AL422B_TEST_PATTERN_EN
        lit_first = 8'h00;
        lit_last  = 8'h13;
`else
        lit_first = 10;
        lit_last  = 21;
`endif
        reset = 1'b1;
        arm = 1'b0;
        frame_valid = 1'b0;
        line_valid = 1'b0;
        pix_data = 8'd0;
        @(posedge clk);
        #1;
        check("rst_wrst_n", int'(fifo_wrst_n), 1);
        check("rst_we_n", int'(fifo_we_n), 1);
        check("rst_di", int'(fifo_di), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(frame_done), 0);
        check("rst_short", int'(short_frame), 0);
        check("rst_pix_count", int'(pix_count), 0);
        @(negedge clk);
        reset = 1'b0;

        // Frames with no arm: nothing happens.
        send_frame(3, 8);
        send_frame(3, 8);
        check("idle_writes", wr_seen, 0);
        check("idle_wrst", wrst_pulses, 0);
        check("idle_busy", int'(busy), 0);
        check("idle_done", done_cnt, 0);

        // Full capture.
        capture(3, 8, 0);
        check("first_write_literal", first_wr, lit_first);
        check("last_write_literal", last_wr, lit_last);

        // Arm mid-frame: that frame is skipped, the next one is captured.
        prev_done = done_cnt;
        frame_wr = 0;
        fork
            send_frame(3, 8);
            begin
                repeat (5) @(negedge clk);
                arm = 1'b1;
                @(negedge clk);
                arm = 1'b0;
            end
        join
        check("midarm_no_write", frame_wr, 0);
        check("midarm_busy", int'(busy), 1);
        expect_frame(3, 8);
        send_frame(3, 8);
        repeat (4) @(negedge clk);
        check("midarm_done", done_cnt, prev_done + 1);
        check("midarm_writes", frame_wr, 8);
        check("midarm_pix_count", int'(pix_count), 8);
        check("midarm_short", int'(short_frame), 0);

        // Short frame: only one window line reached.
        capture(2, 4, 1);

        // Reset after three writes of a capture, then a clean capture.
        prev_done = done_cnt;
        prev_wr = wr_seen;
        expect_frame(3, 8);
        arm_pulse();
        repeat (8) @(negedge clk);
        fork
            send_frame(3, 8);
            begin
                reached = 0;
                for (int i = 0; i < 300 && !reached; i++) begin
                    @(posedge clk);
                    #2;
                    if (wr_seen >= prev_wr + 3) reached = 1;
                end
                check("reset_wait_3_writes", reached, 1);
                #1;
                reset = 1'b1;
                #1;
                check("arst_we_n", int'(fifo_we_n), 1);
                check("arst_wrst_n", int'(fifo_wrst_n), 1);
                check("arst_di", int'(fifo_di), 0);
                check("arst_busy", int'(busy), 0);
                check("arst_pix_count", int'(pix_count), 0);
                check("arst_short", int'(short_frame), 0);
                exp_q.delete();
            end
        join
        check("arst_writes", wr_seen, prev_wr + 3);
        check("arst_no_done", done_cnt, prev_done);
        @(negedge clk);
        reset = 1'b0;
        capture(3, 8, 0);
        check("post_reset_first", first_wr, lit_first);
        check("post_reset_last", last_wr, lit_last);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
